mux_nto1_rr: RTL and testbench

- Parametrised successor to the plain 8-to-1 mux: N channels, WIDTH bits each, valid/ready handshake on every input and on the output.
- Selection is either fixed (external sel) or round-robin.
- Output is registered, with 1-cycle latency and full throughput under continuous out_ready.
- Sits between multiple producers and a single downstream consumer in datapath and test infrastructure.

---
 rtl/mux_nto1_rr_pkg.sv | 18 +
 rtl/mux_nto1_rr_arbiter.sv | 26 ++
 rtl/mux_nto1_rr.sv | 106 ++++++++++
 tb/tb_mux_nto1_rr.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_nto1_rr_pkg.sv
// Shared types and helpers for the N-to-1 valid/ready multiplexer.
package mux_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;

  localparam int STAT_W = 16;

  // Index of the set bit of a one-hot vector (0 when the vector is zero).
  function automatic logic [4:0] onehot_idx(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 32; i++) begin
      r = r | ({5{v[i]}} & 5'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo N.
module rr_arbiter #(
  parameter int N = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant
);

  logic found_s;
  logic hit_s;

  // First requester after the pointer wins; the found flag masks later ones.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      hit_s = req[(int'(ptr) + k) % N] & ~found_s;
      grant[(int'(ptr) + k) % N] = hit_s;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 valid/ready mux with fixed or round-robin selection and a registered output.
// Optional transfer counter enabled by defining MUX_NTO1_STATS_EN.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_NTO1_STATS_EN
  ,
  input  logic               cnt_clr,
  output logic [STAT_W-1:0]  xfer_cnt
`endif
);

  localparam logic [SELW:0]   N_W      = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

  mux_mode_e         mode_s;
  logic [SELW-1:0]   last_r;
  logic [N-1:0]      grant_rr_s;
  logic [N-1:0]      grant_fix_s;
  logic [N-1:0]      grant_s;
  logic [SELW-1:0]   gidx_s;
  logic [WIDTH-1:0]  sel_data_s;
  logic              load_en_s;
  logic              xfer_s;

  assign mode_s = mux_mode_e'(mode);

  rr_arbiter #(.N(N)) u_arb (
    .req   (in_valid),
    .ptr   (last_r),
    .grant (grant_rr_s)
  );

  // Fixed-mode grant; an out-of-range select grants nothing.
  always_comb begin
    grant_fix_s = '0;
    if ({1'b0, sel} < N_W) begin
      grant_fix_s[sel] = in_valid[sel];
    end else begin
      grant_fix_s = '0;
    end
  end

  // Final grant, handshake and data selection.
  always_comb begin
    grant_s    = (mode_s == MODE_RR) ? grant_rr_s : grant_fix_s;
    load_en_s  = ~out_valid | out_ready;
    in_ready   = grant_s & {N{load_en_s}};
    xfer_s     = load_en_s & (|grant_s);
    gidx_s     = SELW'(onehot_idx(32'(grant_s)));
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  // Output register and RR pointer; only RR-mode transfers move the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_r    <= LAST_RST;
    end else if (xfer_s) begin
      out_valid <= 1'b1;
      out_data  <= sel_data_s;
      out_ch    <= gidx_s;
      last_r    <= (mode_s == MODE_RR) ? gidx_s : last_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef MUX_NTO1_STATS_EN
  // Saturating handshake counter; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (cnt_clr) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end else begin
      xfer_cnt <= xfer_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr (N=8, WIDTH=8); covers MUX_NTO1_STATS_EN when defined.
module tb_mux_nto1_rr;

  localparam int N = 8;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             mode;
  logic [2:0]       sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_ch;
  logic             out_valid;
  logic             out_ready;
`ifdef MUX_NTO1_STATS_EN
  logic             cnt_clr;
  logic [15:0]      xfer_cnt;
`endif

  int total = 0;
  int bad = 0;

  beat_t sbq[$];
  int    m_last;
  bit    m_valid;
  logic [2:0] m_ch;
  logic [7:0] m_data;
  logic [2:0] obs_ch;

  mux_nto1_rr #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_NTO1_STATS_EN
    ,
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_last  = N - 1;
    m_valid = 1'b0;
    m_ch    = 3'd0;
    m_data  = 8'd0;
    sbq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: predict grant, check in_ready, push expected beat, check output after the edge.
  task automatic step();
    bit found;
    bit load;
    int g;
    int idx;
    logic [7:0] exp_rdy;
    beat_t b;
    #1;
    found = 1'b0;
    g = 0;
    if (mode == 1'b0) begin
      if (in_valid[sel]) begin
        found = 1'b1;
        g = int'(sel);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
    end
    load = !m_valid || out_ready;
    exp_rdy = (load && found) ? (8'd1 << g) : 8'd0;
    total++;
    if (in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL in_ready: got %h want %h", in_ready, exp_rdy);
    end
    if (load && found) begin
      b.ch = 3'(g);
      b.data = in_data[g*WIDTH +: WIDTH];
      sbq.push_back(b);
      if (mode == 1'b1) m_last = g;
      m_valid = 1'b1;
      m_ch = b.ch;
      m_data = b.data;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== m_valid) begin
      bad++;
      $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
    end
    if (load && found) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
        b = sbq.pop_front();
        total++;
        if ({out_ch, out_data} !== {b.ch, b.data}) begin
          bad++;
          $display("FAIL beat: got ch=%0d data=%h want ch=%0d data=%h", out_ch, out_data, b.ch, b.data);
        end
      end
    end else if (m_valid) begin
      total++;
      if ({out_ch, out_data} !== {m_ch, m_data}) begin
        bad++;
        $display("FAIL hold: got ch=%0d data=%h want ch=%0d data=%h", out_ch, out_data, m_ch, m_data);
      end
    end
    obs_ch = out_ch;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 8'h00;
    #3;
    total++;
    if ({out_valid, out_data, out_ch, in_ready} !== 20'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h ch=%0d rdy=%h want all zero", out_valid, out_data, out_ch, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fixed();
    mode = 1'b0;
    sel = 3'd3;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (in_ready !== 8'h08) begin
        bad++;
        $display("FAIL fixed_ready: got %h want 08", in_ready);
      end
      step();
      total++;
      if ({out_ch, out_data} !== {3'd3, 8'h13}) begin
        bad++;
        $display("FAIL fixed_beat: got ch=%0d data=%h want ch=3 data=13", out_ch, out_data);
      end
    end
    sel = 3'd5;
    in_valid = 8'hDF;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL fixed_novalid: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] alt [4];
    alt[0] = 3'd5; alt[1] = 3'd7; alt[2] = 3'd5; alt[3] = 3'd7;
    do_reset();
    mode = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      total++;
      if (obs_ch !== 3'(c % 8)) begin
        bad++;
        $display("FAIL rr_seq: got ch=%0d want %0d", obs_ch, c % 8);
      end
    end
    in_valid = 8'b1010_0000;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs_ch !== alt[c]) begin
        bad++;
        $display("FAIL rr_alt: got ch=%0d want %0d", obs_ch, alt[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if ({in_ready, out_ch, out_data, out_valid} !== {8'h00, 3'd0, 8'h10, 1'b1}) begin
        bad++;
        $display("FAIL bp_hold: got rdy=%h ch=%0d data=%h v=%b want 00/0/10/1", in_ready, out_ch, out_data, out_valid);
      end
    end
    out_ready = 1'b1;
    step();
    total++;
    if (obs_ch !== 3'd1) begin
      bad++;
      $display("FAIL bp_release: got ch=%0d want 1", obs_ch);
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL bp_leftover: got %0d queued want 0", sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();
    total++;
    if (obs_ch !== 3'd0) begin
      bad++;
      $display("FAIL reset_first: got ch=%0d want 0", obs_ch);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    mode = 1'b0;
    sel = 3'd6;
    step();
    total++;
    if (obs_ch !== 3'd6) begin
      bad++;
      $display("FAIL mode_fixed: got ch=%0d want 6", obs_ch);
    end
    mode = 1'b1;
    step();
    total++;
    if (obs_ch !== 3'd3) begin
      bad++;
      $display("FAIL mode_rr_resume: got ch=%0d want 3", obs_ch);
    end
  endtask

`ifdef MUX_NTO1_STATS_EN
  task automatic test_stats();
    do_reset();
    total++;
    if (xfer_cnt !== 16'd0) begin
      bad++;
      $display("FAIL cnt_reset: got %h want 0000", xfer_cnt);
    end
    mode = 1'b0;
    sel = 3'd3;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    repeat (70001) @(posedge clk);
    #1;
    total++;
    if (xfer_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL cnt_sat: got %h want ffff", xfer_cnt);
    end
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    total++;
    if (xfer_cnt !== 16'd0) begin
      bad++;
      $display("FAIL cnt_clr: got %h want 0000", xfer_cnt);
    end
    @(posedge clk);
    #1;
    total++;
    if (xfer_cnt !== 16'd1) begin
      bad++;
      $display("FAIL cnt_after_clr: got %h want 0001", xfer_cnt);
    end
    do_reset();
  endtask
`endif

  initial begin
    rst = 1'b1;
    mode = 1'b0;
    sel = 3'd0;
    in_valid = 8'h00;
    out_ready = 1'b1;
`ifdef MUX_NTO1_STATS_EN
    cnt_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      in_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
    end
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_mode_switch();
`ifdef MUX_NTO1_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
